// File: rtl/store_size_sequencer.sv
// Store sequencer in front of a word-wide data memory: sw is a single write,
// sb/sh are read-modify-write with the low byte/halfword replaced.
module store_size_sequencer #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] SIZE_SB = 3'b000;
    localparam logic [2:0] SIZE_SW = 3'b001;
    localparam logic [2:0] SIZE_SH = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        req_ready_q, req_ready_d;

    // Bits of the old word that survive the merge.
    logic [31:0] keep_mask;
    logic [31:0] merged;

    always_comb begin
        keep_mask = (size_q == SIZE_SB) ? 32'hFFFF_FF00 : 32'hFFFF_0000;
        merged    = (mem_rdata & keep_mask) | (data_q & ~keep_mask);
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d     = req_size;
                    data_d     = req_data;
                    mem_addr_d = req_addr;
                    if (req_size == SIZE_SW) begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        done_d      = 1'b1;
                        mem_wdata_d = req_data;
                    end else if (req_size == SIZE_SB || req_size == SIZE_SH) begin
                        state_d  = READ;
                        mem_rd_d = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = 4'(MEM_LATENCY - 1);
            end
            WAIT: begin
                // Read data is valid in the cycle the counter sits at zero.
                if (cnt_q == 4'd0) begin
                    state_d     = WRITE;
                    mem_wr_d    = 1'b1;
                    done_d      = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            size_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_size_sequencer.sv
// Bench for store_size_sequencer: two instances (latency 1 and 3), a
// cycle-scheduled expectation model, per-cycle compare and directed tests.
module tb_store_size_sequencer;

    localparam int          LAT0 = 1;
    localparam int          LAT1 = 3;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid [2];
    logic [2:0]  req_size  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_data  [2];
    logic        req_ready [2];
    logic [31:0] mem_addr  [2];
    logic        mem_rd    [2];
    logic        mem_wr    [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        done      [2];
    logic        err       [2];

    logic [31:0] mem_val [2];
    logic [15:0] rd_pipe [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    // Expected schedule: cycle numbers of each strobe, -1 when none pending.
    int          acc_t [2];
    int          e_rd  [2];
    int          e_wr  [2];
    int          e_err [2];
    int          busy  [2];
    logic [31:0] e_addr    [2];
    logic [31:0] e_wdata   [2];
    logic [31:0] e_wd_next [2];

    int          wr_seen  [2] = '{0, 0};
    int          rd_seen  [2] = '{0, 0};
    int          err_seen [2] = '{0, 0};
    int          last_wr_cyc [2] = '{0, 0};
    int          last_rd_cyc [2] = '{0, 0};
    int          last_err_cyc[2] = '{0, 0};
    logic [31:0] last_wd [2] = '{32'h0, 32'h0};

    always #5 clk = ~clk;

    store_size_sequencer #(.MEM_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_size(req_size[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .done(done[0]), .err(err[0])
    );

    store_size_sequencer #(.MEM_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_size(req_size[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .done(done[1]), .err(err[1])
    );

    // Memory: data is valid only in the cycle exactly LAT after the read strobe.
    assign mem_rdata[0] = rd_pipe[0][LAT0-1] ? mem_val[0] : JUNK;
    assign mem_rdata[1] = rd_pipe[1][LAT1-1] ? mem_val[1] : JUNK;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] sz, input logic [31:0] old,
                                                input logic [31:0] dat);
        logic [31:0] low;
        low = (sz == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (old & ~low) | (dat & low);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            rd_pipe[d] <= {rd_pipe[d][14:0], mem_rd[d]};
            if (!reset_n) begin
                rd_pipe[d]   <= '0;
                acc_t[d]     <= -1;
                e_rd[d]      <= -1;
                e_wr[d]      <= -1;
                e_err[d]     <= -1;
                busy[d]      <= -1;
                e_addr[d]    <= '0;
                e_wdata[d]   <= '0;
                e_wd_next[d] <= '0;
            end else begin
                if (cyc == e_wr[d]) e_wdata[d] <= e_wd_next[d];
                if (req_valid[d] && cyc > busy[d]) begin
                    acc_t[d]  <= cyc;
                    e_addr[d] <= req_addr[d];
                    case (req_size[d])
                        3'b001: begin
                            e_wr[d]      <= cyc + 1;
                            busy[d]      <= cyc + 1;
                            e_wd_next[d] <= req_data[d];
                        end
                        3'b000, 3'b010: begin
                            e_rd[d]      <= cyc + 1;
                            e_wr[d]      <= cyc + 2 + lat_of(d);
                            busy[d]      <= cyc + 2 + lat_of(d);
                            e_wd_next[d] <= store_merge(req_size[d], mem_val[d], req_data[d]);
                        end
                        default: begin
                            e_err[d] <= cyc + 1;
                            busy[d]  <= cyc + 1;
                        end
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ready%0d@%0d", d, cyc), {31'b0, req_ready[d]}, {31'b0, cyc > busy[d]});
                chk($sformatf("rd%0d@%0d", d, cyc), {31'b0, mem_rd[d]}, {31'b0, cyc == e_rd[d]});
                chk($sformatf("wr%0d@%0d", d, cyc), {31'b0, mem_wr[d]}, {31'b0, cyc == e_wr[d]});
                chk($sformatf("done%0d@%0d", d, cyc), {31'b0, done[d]}, {31'b0, cyc == e_wr[d]});
                chk($sformatf("err%0d@%0d", d, cyc), {31'b0, err[d]}, {31'b0, cyc == e_err[d]});
                chk($sformatf("addr%0d@%0d", d, cyc), mem_addr[d], e_addr[d]);
                chk($sformatf("wdata%0d@%0d", d, cyc), mem_wdata[d],
                    (cyc == e_wr[d]) ? e_wd_next[d] : e_wdata[d]);
                if (mem_wr[d]) begin
                    wr_seen[d]     <= wr_seen[d] + 1;
                    last_wr_cyc[d] <= cyc;
                    last_wd[d]     <= mem_wdata[d];
                end
                if (mem_rd[d]) begin
                    rd_seen[d]     <= rd_seen[d] + 1;
                    last_rd_cyc[d] <= cyc;
                end
                if (err[d]) begin
                    err_seen[d]     <= err_seen[d] + 1;
                    last_err_cyc[d] <= cyc;
                end
            end
        end
    end

    task automatic do_req(input int d, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] dt);
        int n = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_size[d]  = sz;
        req_addr[d]  = a;
        req_data[d]  = dt;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[d] && n < 50);
        if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int w, r, e;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_size[d]  = 3'b000;
            req_addr[d]  = '0;
            req_data[d]  = '0;
            mem_val[d]   = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        started = 1'b1;
        chk("reset_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("reset_addr", mem_addr[1], 32'h0);
        chk("reset_wdata", mem_wdata[0], 32'h0);
        chk("reset_strobes", {29'b0, mem_rd[0], mem_wr[1], err[1]}, 32'd0);
        reset_n = 1'b1;

        // sw: single write one cycle after accept, no read.
        w = wr_seen[0]; r = rd_seen[0];
        do_req(0, 3'b001, 32'h10, 32'hFFFF_FFFF);
        wait_idle(0);
        chk("sw_wr_count", wr_seen[0] - w, 32'd1);
        chk("sw_rd_count", rd_seen[0] - r, 32'd0);
        chk("sw_wr_cycle", last_wr_cyc[0] - acc_t[0], 32'd1);
        chk("sw_wdata", last_wd[0], 32'hFFFF_FFFF);
        chk("sw_addr", mem_addr[0], 32'h10);

        // sb, latency 1: read at t+1, write at t+3.
        mem_val[0] = 32'h0;
        w = wr_seen[0];
        do_req(0, 3'b000, 32'h20, 32'hFFFF_FFFF);
        wait_idle(0);
        chk("sb_rd_cycle", last_rd_cyc[0] - acc_t[0], 32'd1);
        chk("sb_wr_cycle", last_wr_cyc[0] - acc_t[0], 32'd3);
        chk("sb_wdata", last_wd[0], 32'h0000_00FF);
        chk("sb_wr_count", wr_seen[0] - w, 32'd1);

        // sh, latency 3: write at t+5.
        mem_val[1] = 32'h1234_5678;
        do_req(1, 3'b010, 32'h24, 32'hAAAA_BBBB);
        wait_idle(1);
        chk("sh_rd_cycle", last_rd_cyc[1] - acc_t[1], 32'd1);
        chk("sh_wr_cycle", last_wr_cyc[1] - acc_t[1], 32'd5);
        chk("sh_wdata", last_wd[1], 32'h1234_BBBB);

        // Illegal size, then a normal sw.
        w = wr_seen[0]; r = rd_seen[0]; e = err_seen[0];
        do_req(0, 3'b011, 32'h30, 32'h55);
        wait_idle(0);
        chk("ill_ready_cycle", cyc - acc_t[0], 32'd2);
        chk("ill_err_cycle", last_err_cyc[0] - acc_t[0], 32'd1);
        chk("ill_err_count", err_seen[0] - e, 32'd1);
        chk("ill_no_strobes", (wr_seen[0] - w) + (rd_seen[0] - r), 32'd0);
        chk("ill_addr", mem_addr[0], 32'h30);
        do_req(0, 3'b001, 32'h44, 32'h0BAD_F00D);
        wait_idle(0);
        chk("post_ill_wr_count", wr_seen[0] - w, 32'd1);
        chk("post_ill_wdata", last_wd[0], 32'h0BAD_F00D);

        // Reset while an sb sits in WAIT.
        mem_val[1] = 32'hFFFF_FFFF;
        w = wr_seen[1];
        do_req(1, 3'b000, 32'h50, 32'h12);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_mid_ready", {31'b0, req_ready[1]}, 32'd1);
        chk("rst_mid_addr", mem_addr[1], 32'h0);
        chk("rst_mid_wdata", mem_wdata[1], 32'h0);
        chk("rst_mid_wdata0", mem_wdata[0], 32'h0);
        repeat (8) @(negedge clk);
        chk("rst_mid_no_write", wr_seen[1] - w, 32'd0);

        // Busy: requests held during an sh must be ignored.
        mem_val[1] = 32'hCAFE_0000;
        w = wr_seen[1];
        do_req(1, 3'b010, 32'h60, 32'h0000_1111);
        for (int i = 0; i < 4; i++) begin
            req_valid[1] = 1'b1;
            req_size[1]  = 3'b001;
            req_addr[1]  = 32'h70;
            req_data[1]  = 32'h2222_2222 + i;
            chk($sformatf("busy_ready_%0d", i), {31'b0, req_ready[1]}, 32'd0);
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        wait_idle(1);
        chk("busy_wdata", last_wd[1], 32'hCAFE_1111);
        chk("busy_wr_count", wr_seen[1] - w, 32'd1);
        chk("busy_addr", mem_addr[1], 32'h60);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_size_sequencer.md
# store_size_sequencer

Multicycle store controller that sits in front of the word-wide data memory and sequences sub-word stores (sb, sh) as read-modify-write operations. Full-word stores (sw) go straight to a single write. The block accepts one store request at a time from the control unit. It issues the memory read, captures the old word, and merges the register-B data into the low byte or halfword. It then writes the merged word back and pulses completion.

## Interface
- MEM_LATENCY, 1: cycles from the `mem_rd` cycle to the cycle in which `mem_rdata` is valid; legal range 1..15.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  store request present.
- req_ready  out  1  block idle and able to accept; a request is taken when req_valid && req_ready.
- req_size  in  3  store size: 000 = sb, 001 = sw, 010 = sh, any other value is illegal.
- req_addr  in  32  word address of the store.
- req_data  in  32  register-B value to store.
- mem_addr  out  32  memory address, registered.
- mem_rd  out  1  one-cycle read strobe.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  32  write data, valid while mem_wr = 1.
- mem_rdata  in  32  memory read data.
- done  out  1  one-cycle pulse, coincident with mem_wr.
- err  out  1  one-cycle pulse for an illegal req_size.

## Operation
- States:
  - IDLE: req_ready = 1.
  - READ: mem_rd = 1 for exactly one cycle.
  - WAIT: latency counter runs.
  - WRITE: mem_wr = 1 and done = 1 for one cycle.
  - ERR: err = 1 for one cycle.
- Accept (IDLE):
  - req_size, req_addr and req_data are latched into internal registers.
  - mem_addr is loaded with req_addr.
  - sw goes to WRITE; sb and sh go to READ; an illegal size goes to ERR.
- READ → WAIT.
  - The counter is loaded with MEM_LATENCY−1 and decrements each WAIT cycle.
- WAIT exit: when the counter reaches 0, mem_rdata is sampled on that edge, the merge is computed, and the state moves to WRITE.
- Merge rules:
  - sb: {old[31:8], data[7:0]}.
  - sh: {old[31:16], data[15:0]}.
  - sw: data[31:0]; old data is never read.
- WRITE → IDLE. ERR → IDLE.
  - ERR issues no memory strobe, and mem_addr still updates.
- Inputs presented outside IDLE are ignored: req_ready = 0, and latched values are unaffected.
- mem_rd and mem_wr are never both 1 in the same cycle.
- mem_addr holds its value from accept until the next accept.
- mem_wdata holds its last written value; it is only meaningful during WRITE.
- Reset values:
  - State is IDLE and req_ready = 1.
  - mem_rd, mem_wr, done and err are 0.
  - mem_addr and mem_wdata are 0x00000000.
  - The latch registers and the counter are 0.
- Reset mid-operation (any state): return to IDLE on that edge.
  - A pending read result is discarded.
  - No write is issued for the aborted request.

## Timing
- The request is accepted at edge t, which is the end of the IDLE cycle.
- sw: mem_wr, done and mem_wdata = req_data are asserted in cycle t+1. req_ready = 1 again in cycle t+2.
- sb/sh:
  - mem_rd is asserted in cycle t+1.
  - mem_rdata is sampled at the end of cycle t+1+MEM_LATENCY.
  - mem_wr and done are asserted in cycle t+2+MEM_LATENCY.
  - req_ready returns in cycle t+3+MEM_LATENCY.
  - With MEM_LATENCY = 1: read at t+1, write at t+3.
- Illegal size: err is asserted in cycle t+1, and req_ready = 1 in cycle t+2.
- Back-to-back requests: the earliest next accept is in the first cycle with req_ready = 1. There is no bubble-free overlap.

## Test plan
- Reset, then sw:
  - Stimulus: size 001, addr 0x10, data 0xFFFFFFFF.
  - Required: exactly one mem_wr, at t+1, with mem_addr 0x10 and mem_wdata 0xFFFFFFFF; mem_rd never asserted; done coincident with mem_wr.
- sb, MEM_LATENCY = 1:
  - Stimulus: size 000, data 0xFFFFFFFF; memory returns 0x00000000.
  - Required: mem_rd at t+1; write at t+3 of 0x000000FF.
- sh, MEM_LATENCY = 3:
  - Stimulus: memory returns 0x12345678; data 0xAAAABBBB.
  - Required: write at t+5 of 0x1234BBBB.
- Illegal size:
  - Stimulus: size 011.
  - Required: err at t+1; no mem_rd or mem_wr; req_ready back at t+2; a following sw completes normally.
- Reset mid-operation:
  - Stimulus: assert reset_n = 0 during WAIT of an sb.
  - Required: no mem_wr ever issued for that request; all outputs at their reset values on the next cycle; req_ready = 1.
- Busy behaviour:
  - Stimulus: hold req_valid high with changing data during an sh.
  - Required: req_ready stays 0 throughout the operation, and the written data reflects only the first accepted request.
